// File: rtl/lsu_bus_pkg.sv
// Shared types and lane helpers for the LSU bus master.
// Size encoding, FSM states and the read-timeout default live here.
package lsu_bus_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR      = 2'd2,
        ST_RSP     = 2'd3
    } state_e;

    localparam int TIMEOUT_DEF = 16;

    // Illegal size or an address not aligned to the access size.
    function automatic logic misaligned(size_e sz, logic [1:0] off);
        logic bad;
        bad = 1'b0;
        unique case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_strobe(size_e sz, logic [1:0] off);
        logic [3:0] s;
        s = 4'b0000;
        unique case (sz)
            SZ_BYTE: s = 4'b0001 << off;
            SZ_HALF: s = 4'b0011 << off;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] lane_data(size_e sz, logic [31:0] d);
        logic [31:0] r;
        r = d;
        unique case (sz)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Core request/response and memory-bus signals of the LSU master.
// master = the LSU itself, slave = core plus responder side.
interface lsu_bus_master_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RspValid;
    logic [31:0] RspData;
    logic        RspErr;
    logic        RRdy;
    logic        RVld;
    logic [31:0] RAddr;
    logic [31:0] RData;
    logic        RWEn;
    logic [3:0]  RWStrobe;
    logic [31:0] RWData;

    modport master (
        input  ReqValid, ReqWrite, ReqSize, ReqUnsigned,
        input  ReqAddr, ReqWData, RVld, RData,
        output ReqReady, RspValid, RspData, RspErr,
        output RRdy, RAddr, RWEn, RWStrobe, RWData
    );

    modport slave (
        output ReqValid, ReqWrite, ReqSize, ReqUnsigned,
        output ReqAddr, ReqWData, RVld, RData,
        input  ReqReady, RspValid, RspData, RspErr,
        input  RRdy, RAddr, RWEn, RWStrobe, RWData
    );

endinterface

// File: rtl/lsu_load_align.sv
// Shifts the read word down to the accessed byte lane,
// then truncates and sign/zero-extends to the access size.
module lsu_load_align
    import lsu_bus_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] sh;

    assign sh = word >> {off, 3'b000};

    // Truncate and extend the shifted word.
    always_comb begin
        data = sh;
        unique case (size)
            SZ_BYTE: data = uns ? {24'h0, sh[7:0]}
                                : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: data = uns ? {16'h0, sh[15:0]}
                                : {{16{sh[15]}}, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Single-outstanding load/store master between the core and a simple
// read/write bus; loads wait for RVld with a timeout, stores are one pulse.
module lsu_bus_master
    import lsu_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    lsu_bus_master_if.master bus
);

    state_e      state;
    logic [7:0]  cnt;
    size_e       size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [31:0] ld_data;
    size_e       req_sz;
    logic        req_bad;

    assign req_sz       = size_e'(bus.ReqSize);
    assign req_bad      = misaligned(req_sz, bus.ReqAddr[1:0]);
    assign bus.ReqReady = (state == ST_IDLE);

    lsu_load_align u_align (
        .word (bus.RData),
        .off  (off_q),
        .size (size_q),
        .uns  (uns_q),
        .data (ld_data)
    );

    // Transaction FSM with all bus and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            bus.RRdy     <= 1'b0;
            bus.RWEn     <= 1'b0;
            bus.RspValid <= 1'b0;
            bus.RspErr   <= 1'b0;
            bus.RspData  <= 32'h0;
            bus.RAddr    <= 32'h0;
            bus.RWData   <= 32'h0;
            bus.RWStrobe <= 4'h0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.ReqValid) begin
                        size_q <= req_sz;
                        uns_q  <= bus.ReqUnsigned;
                        off_q  <= bus.ReqAddr[1:0];
                        cnt    <= 8'd0;
                        if (req_bad) begin
                            bus.RspValid <= 1'b1;
                            bus.RspErr   <= 1'b1;
                            bus.RspData  <= 32'h0;
                            state        <= ST_RSP;
                        end else if (bus.ReqWrite) begin
                            bus.RAddr    <= {bus.ReqAddr[31:2], 2'b00};
                            bus.RWEn     <= 1'b1;
                            bus.RWStrobe <= lane_strobe(req_sz, bus.ReqAddr[1:0]);
                            bus.RWData   <= lane_data(req_sz, bus.ReqWData);
                            state        <= ST_WR;
                        end else begin
                            bus.RAddr <= {bus.ReqAddr[31:2], 2'b00};
                            bus.RRdy  <= 1'b1;
                            state     <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (bus.RVld) begin
                        bus.RRdy     <= 1'b0;
                        bus.RspValid <= 1'b1;
                        bus.RspErr   <= 1'b0;
                        bus.RspData  <= ld_data;
                        state        <= ST_RSP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        bus.RRdy     <= 1'b0;
                        bus.RspValid <= 1'b1;
                        bus.RspErr   <= 1'b1;
                        bus.RspData  <= 32'h0;
                        state        <= ST_RSP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_WR: begin
                    bus.RWEn     <= 1'b0;
                    bus.RspValid <= 1'b1;
                    bus.RspErr   <= 1'b0;
                    bus.RspData  <= 32'h0;
                    state        <= ST_RSP;
                end
                ST_RSP: begin
                    bus.RspValid <= 1'b0;
                    bus.RspErr   <= 1'b0;
                    cnt          <= 8'd0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: table vectors, hand sequences and random
// traffic against a byte-addressed memory model.
module tb_lsu_bus_master;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_bus_master_if bus();

    lsu_bus_master #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // responder
    logic [31:0] rmem [int];
    int fixed_delay = 1;
    bit resp_en = 1'b1;
    int dly = -1;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        int k;
        k = int'(a >> 2);
        if (rmem.exists(k)) return rmem[k];
        return 32'h0;
    endfunction

    // Bus responder: drives RVld/RData and commits writes, on negedges.
    always @(negedge clk) begin
        if (rst) begin
            bus.RVld  = 1'b0;
            bus.RData = $urandom;
            dly = -1;
        end else begin
            if (bus.RWEn) begin
                logic [31:0] w;
                w = rd_word(bus.RAddr);
                for (int j = 0; j < 4; j++)
                    if (bus.RWStrobe[j]) w[8*j +: 8] = bus.RWData[8*j +: 8];
                rmem[int'(bus.RAddr >> 2)] = w;
            end
            if (bus.RVld) begin
                bus.RVld  = 1'b0;
                bus.RData = $urandom;
            end else if (bus.RRdy && resp_en) begin
                if (dly < 0)
                    dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                if (dly == 0) begin
                    bus.RVld  = 1'b1;
                    bus.RData = rd_word(bus.RAddr);
                    dly = -1;
                end else begin
                    dly--;
                end
            end else if (!bus.RRdy) begin
                dly = -1;
            end
        end
    end

    // reference model
    logic [7:0]  ref_mem [int];
    logic [31:0] exp_data;
    logic        exp_err;
    logic [3:0]  exp_stb;
    logic [31:0] exp_wd;

    task automatic ref_step(input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a,
                            input logic [31:0] d);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        exp_err  = (sz == 2'd3) || ((a % 32'(n)) != 0);
        exp_data = 32'h0;
        exp_stb  = 4'h0;
        exp_wd   = 32'h0;
        if (!exp_err) begin
            if (w) begin
                for (int k = 0; k < n; k++) begin
                    ref_mem[int'(a + 32'(k))] = d[8*k +: 8];
                    exp_stb[int'((a + 32'(k)) % 4)] = 1'b1;
                end
                for (int j = 0; j < 4; j++)
                    exp_wd[8*j +: 8] = d[8*(j % n) +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) begin
                    int key;
                    key = int'(a + 32'(k));
                    if (ref_mem.exists(key))
                        v = v | ({24'h0, ref_mem[key]} << (8 * k));
                end
                if (!u && n < 4 && v[8*n-1])
                    v = v | (32'hFFFF_FFFF << (8 * n));
                exp_data = v;
            end
        end
    endtask

    // request driver results
    logic [31:0] got_data, got_wd, got_raddr;
    logic        got_err, timed_out, pulse_one;
    logic [3:0]  got_stb;
    int          got_lat, n_rrdy, n_wen;
    int          n_both = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns one negedge after
    // the response pulse.
    task automatic do_req(input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a,
                          input logic [31:0] d);
        got_data = 0; got_err = 0; got_lat = 0; n_rrdy = 0; n_wen = 0;
        got_stb = 0; got_wd = 0; got_raddr = 0;
        timed_out = 1'b1; pulse_one = 1'b0;
        bus.ReqValid = 1'b1; bus.ReqWrite = w; bus.ReqSize = sz;
        bus.ReqUnsigned = u; bus.ReqAddr = a; bus.ReqWData = d;
        @(negedge clk);
        bus.ReqValid = 1'b0;
        bus.ReqAddr = $urandom; bus.ReqWData = $urandom;
        bus.ReqWrite = 1'($urandom); bus.ReqSize = 2'($urandom);
        bus.ReqUnsigned = 1'($urandom);
        for (int i = 1; i <= 100; i++) begin
            if (bus.RRdy) begin n_rrdy++; got_raddr = bus.RAddr; end
            if (bus.RWEn) begin
                n_wen++; got_stb = bus.RWStrobe; got_wd = bus.RWData;
            end
            if (bus.RRdy && bus.RWEn) n_both++;
            if (bus.RspValid) begin
                got_data = bus.RspData; got_err = bus.RspErr;
                got_lat = i; timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        pulse_one = !bus.RspValid;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ed;
        logic        ee;
        logic [3:0]  es;
        logic [31:0] ew;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0;
        bus.ReqUnsigned = 1'b0; bus.ReqAddr = 32'h0; bus.ReqWData = 32'h0;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'h0, 32'h0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h80,       32'h0,        1'b0, 4'h8, 32'h80808080};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'hFFFFFF80, 1'b0, 4'h0, 32'h0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h00000080, 1'b0, 4'h0, 32'h0};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h200, 32'h80011234, 32'h0,        1'b0, 4'hF, 32'h80011234};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h202, 32'h0,        32'hFFFF8001, 1'b0, 4'h0, 32'h0};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h200, 32'h0,        32'h00001234, 1'b0, 4'h0, 32'h0};
        tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h206, 32'h5555ABCD, 32'h0,        1'b0, 4'hC, 32'hABCDABCD};
        tbl[10] = '{1'b0, 2'd1, 1'b1, 32'h206, 32'h0,        32'h0000ABCD, 1'b0, 4'h0, 32'h0};
        tbl[11] = '{1'b0, 2'd1, 1'b0, 32'h203, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};
        tbl[12] = '{1'b1, 2'd3, 1'b0, 32'h100, 32'h12345678, 32'h0,        1'b1, 4'h0, 32'h0};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'hFFFFFFBE, 1'b0, 4'h0, 32'h0};
        tbl[14] = '{1'b1, 2'd1, 1'b0, 32'h101, 32'h0000FFFF, 32'h0,        1'b1, 4'h0, 32'h0};

        // reset state
        @(negedge clk);
        chk("rst_rrdy", 32'(bus.RRdy), 0);
        chk("rst_rwen", 32'(bus.RWEn), 0);
        chk("rst_rspvalid", 32'(bus.RspValid), 0);
        chk("rst_rsperr", 32'(bus.RspErr), 0);
        chk("rst_raddr", bus.RAddr, 0);
        chk("rst_rwdata", bus.RWData, 0);
        chk("rst_rspdata", bus.RspData, 0);
        chk("rst_strobe", 32'(bus.RWStrobe), 0);
        chk("rst_reqready", 32'(bus.ReqReady), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // table vectors, 1-cycle responder
        fixed_delay = 1;
        for (int i = 0; i < 15; i++) begin
            ref_step(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d);
            do_req(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].d);
            chk($sformatf("t%0d_timeout", i), 32'(timed_out), 0);
            chk($sformatf("t%0d_pulse", i), 32'(pulse_one), 1);
            chk($sformatf("t%0d_err", i), 32'(got_err), 32'(tbl[i].ee));
            chk($sformatf("t%0d_data", i), got_data, tbl[i].ed);
            if (tbl[i].ee) begin
                chk($sformatf("t%0d_err_lat", i), got_lat, 1);
                chk($sformatf("t%0d_err_rrdy", i), n_rrdy, 0);
                chk($sformatf("t%0d_err_rwen", i), n_wen, 0);
            end else if (tbl[i].w) begin
                chk($sformatf("t%0d_st_lat", i), got_lat, 2);
                chk($sformatf("t%0d_st_rwen", i), n_wen, 1);
                chk($sformatf("t%0d_st_rrdy", i), n_rrdy, 0);
                chk($sformatf("t%0d_strobe", i), 32'(got_stb), 32'(tbl[i].es));
                chk($sformatf("t%0d_rwdata", i), got_wd, tbl[i].ew);
            end else begin
                chk($sformatf("t%0d_ld_lat", i), got_lat, 3);
                chk($sformatf("t%0d_ld_rwen", i), n_wen, 0);
                chk($sformatf("t%0d_raddr", i), got_raddr, tbl[i].a & ~32'h3);
            end
        end

        // timeout with a silent responder
        resp_en = 1'b0;
        ref_step(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("to_rrdy_cycles", n_rrdy, 16);
        chk("to_lat", got_lat, 17);
        chk("to_err", 32'(got_err), 1);
        chk("to_data", got_data, 0);
        chk("to_pulse", 32'(pulse_one), 1);

        // reset while waiting for read data
        bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd2;
        bus.ReqUnsigned = 1'b0; bus.ReqAddr = 32'h200;
        @(negedge clk);
        bus.ReqValid = 1'b0;
        chk("mid_rrdy_set", 32'(bus.RRdy), 1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("mid_rrdy_async", 32'(bus.RRdy), 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.RspValid) cnt++;
        end
        chk("mid_no_rsp", cnt, 0);
        rst = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        ref_step(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        chk("post_rst_err", 32'(got_err), 32'(exp_err));
        chk("post_rst_data", got_data, exp_data);
        chk("post_rst_lat", got_lat, 3);

        // random traffic against the model
        fixed_delay = -1;
        for (int i = 0; i < 200; i++) begin
            logic        w, u;
            logic [1:0]  sz;
            logic [31:0] a, d;
            w  = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'h300 + 32'($urandom_range(0, 31));
            d  = $urandom;
            ref_step(w, sz, u, a, d);
            do_req(w, sz, u, a, d);
            chk($sformatf("r%0d_timeout", i), 32'(timed_out), 0);
            chk($sformatf("r%0d_err", i), 32'(got_err), 32'(exp_err));
            chk($sformatf("r%0d_data", i), got_data, exp_data);
            if (!exp_err && w) begin
                chk($sformatf("r%0d_strobe", i), 32'(got_stb), 32'(exp_stb));
                chk($sformatf("r%0d_rwdata", i), got_wd, exp_wd);
            end
            if (!exp_err && !w)
                chk($sformatf("r%0d_raddr", i), got_raddr, a & ~32'h3);
        end

        chk("rrdy_rwen_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles RRdy is held without RVld before error (range 2..255).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ReqValid  input  1  core load/store request present.
REQ-005 ReqReady  output  1  request accepted when ReqValid&ReqReady at clk edge.
REQ-006 ReqWrite  input  1  1=store, 0=load.
REQ-007 ReqSize  input  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-008 ReqUnsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 ReqAddr  input  32  byte address.
REQ-010 ReqWData  input  32  store data, right-justified.
REQ-011 RspValid  output  1  one-cycle completion pulse.
REQ-012 RspData  output  32  aligned, extended load data; 0 for stores/errors.
REQ-013 RspErr  output  1  misaligned, illegal size or timeout; valid with RspValid.
REQ-014 RRdy  output  1  bus read request, held until RVld sampled.
REQ-015 RVld  input  1  responder read-data-valid, one-cycle pulse.
REQ-016 RAddr  output  32  word-aligned byte address (ReqAddr[31:2],2'b00).
REQ-017 RData  input  32  read word, valid only in RVld cycle.
REQ-018 RWEn  output  1  one-cycle write pulse; write commits at that edge.
REQ-019 RWStrobe  output  4  byte-lane enables for write.
REQ-020 RWData  output  32  lane-replicated store data.

Function
REQ-021 States IDLE, RD_WAIT, WR, RSP; ReqReady=1 only in IDLE.
REQ-022 IDLE, accepted legal load -> RD_WAIT; RRdy=1, RAddr valid from next cycle.
REQ-023 RD_WAIT: RVld=1 sampled -> capture RData, clear RRdy at same edge, go RSP.
REQ-024 RD_WAIT: counter reaches TIMEOUT with no RVld -> clear RRdy, RspErr=1, RspData=0, go RSP.
REQ-025 IDLE, accepted legal store -> WR; next cycle RWEn=1 for exactly one cycle, RRdy=0, then RSP.
REQ-026 RSP: RspValid=1 for one cycle, then IDLE; no core-side backpressure.
REQ-027 Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or ReqSize=3: no bus activity, RSP next cycle with RspErr=1.
REQ-028 Strobe: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-029 RWData: byte {4{WData[7:0]}}; half {2{WData[15:0]}}; word WData.
REQ-030 Load data = RData>>(8*addr[1:0]), truncated to size, extended per ReqUnsigned.
REQ-031 Load latency: accept edge N -> RRdy cycle N+1 -> RspValid in the cycle after the RVld cycle (N+3 with 1-cycle responder).
REQ-032 RVld outside RD_WAIT is ignored; RWEn and RRdy are never high together.
REQ-033 Request fields are registered at accept; later ReqAddr/ReqWData changes do not affect the transaction.
REQ-034 All outputs are registered except ReqReady (decoded from state).

Reset
REQ-035 rst asserted: state=IDLE; RRdy, RWEn, RspValid, RspErr=0; RAddr, RWData, RspData=0; RWStrobe=0; counter=0.
REQ-036 Reset mid-transaction abandons it with no RspValid; responder is reset by the same rst.

Structure
REQ-037 Package lsu_bus_pkg holds the size encoding, state enum and TIMEOUT default.
REQ-038 Sub-module lsu_load_align (combinational shift/extend) is instantiated once.

Verification
REQ-039 Word store 0x100 data 0xDEADBEEF, then word load 0x100 -> RWStrobe=4'hF, RspData=0xDEADBEEF, RspErr=0.
REQ-040 Byte store 0x103 data 0x80, signed byte load 0x103 -> RWStrobe=4'h8, RWData=0x80808080, RspData=0xFFFFFF80; unsigned load -> 0x00000080.
REQ-041 Half load 0x102 over word 0x8001_1234 -> signed RspData=0xFFFF8001.
REQ-042 Word load 0x101 -> RspErr=1, RspData=0, RRdy and RWEn stay 0.
REQ-043 Responder never asserts RVld, TIMEOUT=16 -> RRdy high exactly 16 cycles, then RspValid with RspErr=1.
REQ-044 rst asserted while in RD_WAIT -> RRdy=0 immediately, no RspValid; a new load after reset completes normally.
